// File: rtl/exponent_accelerator_hex_pkg.sv
// Shared definitions for the seven-segment register bank: register map,
// CTRL bit positions and the hex-to-segment decode table (segment a = bit 0).
package exponent_accelerator_hex_pkg;

    localparam logic [3:0] ADDR_CTRL         = 4'd0;
    localparam logic [3:0] ADDR_VALUE        = 4'd1;
    localparam logic [3:0] ADDR_BLINK_MASK   = 4'd2;
    localparam logic [3:0] ADDR_BLINK_PERIOD = 4'd3;
    localparam logic [3:0] ADDR_RAW0         = 4'd4;

    localparam int CTRL_DECODE_BIT    = 32'd0;
    localparam int CTRL_BLANK_ALL_BIT = 32'd1;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_decode(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/exponent_accelerator_hex_blink_timer.sv
// Blink prescaler: down-counter reloaded from the period, toggling phase on
// every expiry. A zero period parks the counter and phase at 0.
module exponent_accelerator_hex_blink_timer #(
    parameter int PERIOD_W = 32'd26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    output logic                phase
);

    logic [PERIOD_W-1:0] count_r;
    logic                phase_r;

    // Counter and phase; a period write restarts the phase from 0 even on an expiry cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            phase_r <= 1'b0;
        end else if (load) begin
            count_r <= period;
            phase_r <= 1'b0;
        end else if (period == '0) begin
            count_r <= '0;
            phase_r <= 1'b0;
        end else if (count_r == '0) begin
            count_r <= period;
            phase_r <= ~phase_r;
        end else begin
            count_r <= count_r - PERIOD_W'(1'b1);
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/exponent_accelerator_hex_bank.sv
// Avalon-MM register bank driving NUM_DIGITS seven-segment displays.
// Blinking is built only when EXPONENT_ACCELERATOR_HEX_BLINK_EN is defined.
module exponent_accelerator_hex_bank
    import exponent_accelerator_hex_pkg::*;
#(
    parameter int NUM_DIGITS = 32'd6,
    parameter int ACTIVE_LOW = 32'd1,
    parameter int PERIOD_W   = 32'd26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] out_port
);

    localparam int VALUE_W = 4 * NUM_DIGITS;
    localparam int OUT_W   = 7 * NUM_DIGITS;
    localparam logic [OUT_W-1:0] OUT_OFF = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic                  wr_s;
    logic                  decode_r;
    logic                  blank_all_r;
    logic [VALUE_W-1:0]    value_r;
    logic [6:0]            raw_r [NUM_DIGITS];
    logic [OUT_W-1:0]      out_r;
    logic [OUT_W-1:0]      out_next_s;
    logic [6:0]            pat_s [NUM_DIGITS];
    logic [31:0]           rd_s;
    logic                  blink_phase_s;
    logic [NUM_DIGITS-1:0] blink_mask_s;
    logic                  unused_wdata_s;

    assign wr_s           = chipselect & ~write_n;
    assign unused_wdata_s = ^writedata;

`ifdef EXPONENT_ACCELERATOR_HEX_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_mask_r;
    logic [PERIOD_W-1:0]   blink_period_r;
    logic [PERIOD_W-1:0]   period_next_s;
    logic                  period_load_s;

    assign period_load_s = wr_s && (address == ADDR_BLINK_PERIOD);
    // The timer sees the incoming value on a write so it can reload it immediately
    assign period_next_s = period_load_s ? writedata[PERIOD_W-1:0] : blink_period_r;
    assign blink_mask_s  = blink_mask_r;

    // Blink configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask_r   <= '0;
            blink_period_r <= '0;
        end else begin
            if (wr_s && (address == ADDR_BLINK_MASK)) begin
                blink_mask_r <= writedata[NUM_DIGITS-1:0];
            end
            if (period_load_s) begin
                blink_period_r <= writedata[PERIOD_W-1:0];
            end
        end
    end

    exponent_accelerator_hex_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk    (clk),
        .reset  (reset),
        .period (period_next_s),
        .load   (period_load_s),
        .phase  (blink_phase_s)
    );
`else
    assign blink_phase_s = 1'b0;
    assign blink_mask_s  = '0;
`endif

    // Control, value and raw pattern registers plus the registered pin drive
    always_ff @(posedge clk) begin
        if (reset) begin
            decode_r    <= 1'b1;
            blank_all_r <= 1'b0;
            value_r     <= '0;
            out_r       <= OUT_OFF;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                raw_r[i] <= 7'h00;
            end
        end else begin
            out_r <= out_next_s;
            if (wr_s && (address == ADDR_CTRL)) begin
                decode_r    <= writedata[CTRL_DECODE_BIT];
                blank_all_r <= writedata[CTRL_BLANK_ALL_BIT];
            end
            if (wr_s && (address == ADDR_VALUE)) begin
                value_r <= writedata[VALUE_W-1:0];
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_s && (address == ADDR_RAW0 + 4'(i))) begin
                    raw_r[i] <= writedata[6:0];
                end
            end
        end
    end

    // Per-digit logical pattern: blanking beats decode, decode beats raw
    always_comb begin
        out_next_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blank_all_r || (blink_phase_s && blink_mask_s[i])) begin
                pat_s[i] = SEG_BLANK;
            end else if (decode_r) begin
                pat_s[i] = hex_decode(value_r[4*i +: 4]);
            end else begin
                pat_s[i] = raw_r[i];
            end
            out_next_s[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pat_s[i] : pat_s[i];
        end
    end

    // Zero-wait-state read mux; unmapped addresses read 0
    always_comb begin
        rd_s = 32'h0000_0000;
        case (address)
            ADDR_CTRL: begin
                rd_s[CTRL_DECODE_BIT]    = decode_r;
                rd_s[CTRL_BLANK_ALL_BIT] = blank_all_r;
            end
            ADDR_VALUE: begin
                rd_s[VALUE_W-1:0] = value_r;
            end
`ifdef EXPONENT_ACCELERATOR_HEX_BLINK_EN
            ADDR_BLINK_MASK: begin
                rd_s[NUM_DIGITS-1:0] = blink_mask_r;
            end
            ADDR_BLINK_PERIOD: begin
                rd_s[PERIOD_W-1:0] = blink_period_r;
            end
`endif
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    rd_s[6:0] = rd_s[6:0] | ((address == ADDR_RAW0 + 4'(i)) ? raw_r[i] : 7'h00);
                end
            end
        endcase
    end

    assign readdata = rd_s;
    assign out_port = out_r;

endmodule

// File: tb/tb_exponent_accelerator_hex_bank.sv
// Scoreboard bench for exponent_accelerator_hex_bank (6 digits, active-low pins).
module tb_exponent_accelerator_hex_bank;

    localparam int NUM_DIGITS = 6;
    localparam int OUT_W      = 7 * NUM_DIGITS;

    logic             clk;
    logic             reset;
    logic [3:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [OUT_W-1:0] out_port;

    exponent_accelerator_hex_bank #(
        .NUM_DIGITS (NUM_DIGITS),
        .ACTIVE_LOW (1),
        .PERIOD_W   (26)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]      due;
        logic [OUT_W-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // reference state of the bank as seen by software
    logic       m_decode;
    logic       m_blank;
    logic [23:0] m_value;
    logic [5:0] m_mask;
    logic [6:0] m_raw [NUM_DIGITS];
    int         m_period;
    int         p_base;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    // expected pins on the next edge, from the state after edge 'cyc'
    function automatic logic [OUT_W-1:0] exp_out();
        logic [OUT_W-1:0] o;
        logic [6:0]       p;
        logic             ph;
        ph = (m_period != 0) ? ((((cyc - p_base) / (m_period + 1)) % 2) == 1) : 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (m_blank || (ph && m_mask[i])) p = 7'h00;
            else if (m_decode) p = seg_of(m_value[4*i +: 4]);
            else p = m_raw[i];
            o[7*i +: 7] = ~p;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_decode = 1'b1; m_blank = 1'b0; m_value = 24'h0; m_mask = 6'h0;
        m_period = 0; p_base = 0;
        for (int i = 0; i < NUM_DIGITS; i++) m_raw[i] = 7'h00;
    endtask

    // one clock: queue the expected pins for the coming edge, optionally write
    task automatic clk_step(input logic w, input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        e.due = 32'(cyc + 1);
        e.val = exp_out();
        exp_q.push_back(e);
        chipselect = w; write_n = ~w; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        if (w) begin
            case (a)
                4'd0: begin m_decode = d[0]; m_blank = d[1]; end
                4'd1: m_value = d[23:0];
`ifdef EXPONENT_ACCELERATOR_HEX_BLINK_EN
                4'd2: m_mask = d[5:0];
                4'd3: begin m_period = int'(d & 32'h03FF_FFFF); p_base = cyc; end
`endif
                default: if (a >= 4'd4 && a < 4'd10) m_raw[a - 4'd4] = d[6:0];
            endcase
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0].due) <= cyc) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (out_port !== mon_e.val) begin
                miscompares++;
                $display("FAIL out_port cycle %0d: got %h expected %h", cyc, out_port, mon_e.val);
            end
        end
    end

    task automatic test_reset();
        logic [3:0]  ra [5];
        logic [31:0] re [5];
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 4'd0; writedata = 32'h0;
        model_reset();
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if (out_port !== {OUT_W{1'b1}}) begin
            miscompares++; $display("FAIL reset_pins: got %h expected %h", out_port, {OUT_W{1'b1}});
        end
        reset = 1'b0;
        clk_step(1'b0, 4'd0, 32'h0);
        clk_step(1'b0, 4'd0, 32'h0);
        vectors++;
        if (out_port !== {NUM_DIGITS{7'h40}}) begin
            miscompares++; $display("FAIL post_reset_zero: got %h expected %h", out_port, {NUM_DIGITS{7'h40}});
        end
        ra = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
        re = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int k = 0; k < 5; k++) begin
            address = ra[k]; #1;
            vectors++;
            if (readdata !== re[k]) begin
                miscompares++; $display("FAIL reset_read addr %0d: got %h expected %h", ra[k], readdata, re[k]);
            end
        end
    endtask

    task automatic test_value();
        clk_step(1'b1, 4'd1, 32'h00FE_DCBA);
        clk_step(1'b0, 4'd0, 32'h0);
        vectors++;
        if (out_port !== {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}) begin
            miscompares++; $display("FAIL value_decode: got %h expected %h", out_port,
                                    {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08});
        end
        address = 4'd1; #1;
        vectors++;
        if (readdata !== 32'h00FE_DCBA) begin
            miscompares++; $display("FAIL value_read: got %h expected %h", readdata, 32'h00FE_DCBA);
        end
        clk_step(1'b1, 4'd1, 32'hFFFF_FFFF);
        address = 4'd1; #1;
        vectors++;
        if (readdata !== 32'h00FF_FFFF) begin
            miscompares++; $display("FAIL value_upper_bits: got %h expected %h", readdata, 32'h00FF_FFFF);
        end
        clk_step(1'b0, 4'd0, 32'h0);
        clk_step(1'b1, 4'd1, 32'h00FE_DCBA);
        clk_step(1'b0, 4'd0, 32'h0);
    endtask

    task automatic test_raw();
        logic [3:0]  ra [4];
        logic [31:0] re [4];
        clk_step(1'b1, 4'd0, 32'h0);
        clk_step(1'b1, 4'd6, 32'h0000_0049);
        clk_step(1'b0, 4'd0, 32'h0);
        vectors++;
        if (out_port !== {7'h7F, 7'h7F, 7'h7F, 7'h36, 7'h7F, 7'h7F}) begin
            miscompares++; $display("FAIL raw_digit2: got %h expected %h", out_port,
                                    {7'h7F, 7'h7F, 7'h7F, 7'h36, 7'h7F, 7'h7F});
        end
        clk_step(1'b1, 4'd10, 32'h0000_007F);
        clk_step(1'b0, 4'd0, 32'h0);
        ra = '{4'd6, 4'd0, 4'd10, 4'd9};
        re = '{32'h49, 32'h0, 32'h0, 32'h0};
        for (int k = 0; k < 4; k++) begin
            address = ra[k]; #1;
            vectors++;
            if (readdata !== re[k]) begin
                miscompares++; $display("FAIL raw_read addr %0d: got %h expected %h", ra[k], readdata, re[k]);
            end
        end
    endtask

`ifdef EXPONENT_ACCELERATOR_HEX_BLINK_EN
    task automatic test_blink();
        clk_step(1'b1, 4'd0, 32'h1);
        clk_step(1'b1, 4'd2, 32'h1);
        clk_step(1'b1, 4'd3, 32'h3);
        while (cyc - p_base < 19) begin
            clk_step(1'b0, 4'd0, 32'h0);
            if (cyc - p_base == 6) begin
                vectors++;
                if (out_port[13:0] !== {7'h03, 7'h7F}) begin
                    miscompares++; $display("FAIL blink_off_phase: got %h expected %h", out_port[13:0], {7'h03, 7'h7F});
                end
            end
        end
        // this write lands on an expiry edge and must restart the phase at 0
        clk_step(1'b1, 4'd3, 32'h3);
        clk_step(1'b0, 4'd0, 32'h0);
        vectors++;
        if (out_port[6:0] !== 7'h08) begin
            miscompares++; $display("FAIL blink_restart: got %h expected %h", out_port[6:0], 7'h08);
        end
        for (int k = 0; k < 14; k++) begin
            if (k == 6) clk_step(1'b1, 4'd2, 32'h2);
            else clk_step(1'b0, 4'd0, 32'h0);
        end
        address = 4'd2; #1;
        vectors++;
        if (readdata !== 32'h2) begin
            miscompares++; $display("FAIL mask_read: got %h expected %h", readdata, 32'h2);
        end
        address = 4'd3; #1;
        vectors++;
        if (readdata !== 32'h3) begin
            miscompares++; $display("FAIL period_read: got %h expected %h", readdata, 32'h3);
        end
    endtask
`else
    task automatic test_no_blink();
        clk_step(1'b1, 4'd0, 32'h1);
        clk_step(1'b1, 4'd3, 32'h3);
        clk_step(1'b1, 4'd2, 32'h3F);
        address = 4'd3; #1;
        vectors++;
        if (readdata !== 32'h0) begin
            miscompares++; $display("FAIL period_unmapped: got %h expected %h", readdata, 32'h0);
        end
        address = 4'd2; #1;
        vectors++;
        if (readdata !== 32'h0) begin
            miscompares++; $display("FAIL mask_unmapped: got %h expected %h", readdata, 32'h0);
        end
        repeat (12) clk_step(1'b0, 4'd0, 32'h0);
    endtask
`endif

    task automatic test_blank_and_reset();
        logic [3:0]  ra [5];
        logic [31:0] re [5];
        clk_step(1'b1, 4'd0, 32'h3);
        repeat (6) clk_step(1'b0, 4'd0, 32'h0);
        vectors++;
        if (out_port !== {OUT_W{1'b1}}) begin
            miscompares++; $display("FAIL blank_all: got %h expected %h", out_port, {OUT_W{1'b1}});
        end
        // reset together with a VALUE write: reset must win
        reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 4'd1; writedata = 32'h0000_0123;
        @(posedge clk); #1;
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        model_reset();
        vectors++;
        if (out_port !== {OUT_W{1'b1}}) begin
            miscompares++; $display("FAIL midrun_reset_pins: got %h expected %h", out_port, {OUT_W{1'b1}});
        end
        ra = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
        re = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int k = 0; k < 5; k++) begin
            address = ra[k]; #1;
            vectors++;
            if (readdata !== re[k]) begin
                miscompares++; $display("FAIL midrun_reset_read addr %0d: got %h expected %h", ra[k], readdata, re[k]);
            end
        end
        repeat (10) clk_step(1'b0, 4'd0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_value();
        test_raw();
`ifdef EXPONENT_ACCELERATOR_HEX_BLINK_EN
        test_blink();
`else
        test_no_blink();
`endif
        test_blank_and_reset();
        @(negedge clk); #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
